// File: rtl/mem_req_sched_pkg.sv
// Shared types for the memory request scheduler.
//   mem_common : the memory request packet carried from requesters to memory.
//   mem_defs   : scheduler default sizes and the drain FSM state encoding.

package mem_common;

  typedef struct packed {
    logic        we;
    logic [3:0]  id;
    logic [31:0] addr;
  } t_mem_req;

endpackage

package mem_defs;

  localparam int MEMSCHED_NREQ  = 2;
  localparam int MEMSCHED_NCRED = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } t_memsched_state;

endpackage

// File: rtl/mem_req_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter. Search starts at ptr_reg and wraps
// modulo NREQ; the pointer moves just past the winner and holds otherwise.

module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [PW-1:0] ptr_reg, ptr_next;
  int            idx;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  assign ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);

  // Advance the priority pointer only when somebody actually won.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ptr_reg <= '0;
    else if (gnt_any) ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/mem_req_sched.sv
// Credit-based memory request scheduler: round-robin over NREQ requesters,
// a single registered output stage toward memory, a credit counter bounding
// outstanding requests, and a drain FSM that stops issue until all
// responses are back. Optional perf counters: MEM_REQ_SCHED_PERF_EN.

module mem_req_sched
  import mem_common::*;
  import mem_defs::*;
#(
  parameter  int NREQ  = MEMSCHED_NREQ,
  parameter  int NCRED = MEMSCHED_NCRED,
  localparam int CW    = $clog2(NCRED + 1),
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  t_mem_req [NREQ-1:0]   req_pkt,
  output logic [NREQ-1:0]       req_gnt,
  output logic                  mem_req_valid,
  output t_mem_req              mem_req_pkt,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CW-1:0]         credits,
  output logic [NREQ-1:0][31:0] perf_gnt_cnt,
  output logic [31:0]           perf_stall_cnt
);

  localparam logic [CW-1:0] CRED_MAX = CW'(NCRED);

  t_memsched_state state_reg, state_next;
  logic [CW-1:0]   credits_reg, credits_next;
  logic            out_valid_reg, out_valid_next;
  t_mem_req        out_pkt_reg, gnt_pkt;
  logic            grant_en, gnt_any, rsp_ok;
  logic [PW-1:0]   gnt_idx;

  // A slot opens when running, a credit is free and the output stage is
  // empty or being handed to memory this same cycle.
  assign grant_en = (state_reg == ST_RUN) && (credits_reg != '0) &&
                    (!out_valid_reg || mem_req_ready);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (grant_en),
    .req     (req_valid),
    .gnt     (req_gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign gnt_pkt = req_pkt[gnt_idx];

  // A response at full credit is illegal and simply ignored (saturation).
  assign rsp_ok = mem_rsp_valid && (credits_reg != CRED_MAX);

  // Credit bookkeeping: grant consumes, response returns, both cancel.
  always_comb begin
    credits_next = credits_reg;
    if (gnt_any && !rsp_ok)      credits_next = credits_reg - CW'(1);
    else if (!gnt_any && rsp_ok) credits_next = credits_reg + CW'(1);
  end

  assign out_valid_next = gnt_any || (out_valid_reg && !mem_req_ready);

  // Drain FSM next state; DRAINED is judged on the values being loaded now
  // so drain_done shows up the cycle after the last response.
  always_comb begin
    state_next = state_reg;
    drain_done = 1'b0;
    case (state_reg)
      ST_RUN:     if (drain_req) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)
          state_next = ST_RUN;
        else if ((credits_next == CRED_MAX) && !out_valid_next)
          state_next = ST_DRAINED;
      end
      ST_DRAINED: begin
        drain_done = 1'b1;
        if (!drain_req) state_next = ST_RUN;
      end
      default:    state_next = ST_RUN;
    endcase
  end

  // State, credits and the output stage; packet only reloads on a grant so
  // it holds steady while memory back-pressures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RUN;
      credits_reg   <= CRED_MAX;
      out_valid_reg <= 1'b0;
      out_pkt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      credits_reg   <= credits_next;
      out_valid_reg <= out_valid_next;
      if (gnt_any) out_pkt_reg <= gnt_pkt;
    end
  end

  assign mem_req_valid = out_valid_reg;
  assign mem_req_pkt   = out_pkt_reg;
  assign credits       = credits_reg;

`ifdef MEM_REQ_SCHED_PERF_EN
  logic        stall_cyc;
  logic [31:0] stall_cnt_reg;

  assign stall_cyc = (|req_valid) && (credits_reg == '0);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_perf_gnt
      logic [31:0] cnt_reg;
      // Per-requester grant count, wraps naturally at 2^32.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)           cnt_reg <= '0;
        else if (req_gnt[gi]) cnt_reg <= cnt_reg + 32'd1;
      end
      assign perf_gnt_cnt[gi] = cnt_reg;
    end
  endgenerate

  // Cycles where someone wanted to go but no credit was left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         stall_cnt_reg <= '0;
    else if (stall_cyc) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end
  assign perf_stall_cnt = stall_cnt_reg;
`else
  assign perf_gnt_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

  a_rsp_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rsp_valid && (credits_reg == CRED_MAX)));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_gnt) && ((req_gnt & ~req_valid) == '0));

endmodule

// File: tb/tb_mem_req_sched.sv
// Testbench for mem_req_sched: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model built from integer
// credit/pointer bookkeeping and a drain mode variable.

`timescale 1ns/1ps
module tb_mem_req_sched;
  import mem_common::*;
  import mem_defs::*;

  localparam int NREQ  = MEMSCHED_NREQ;
  localparam int NCRED = MEMSCHED_NCRED;
  localparam int CW    = $clog2(NCRED + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  t_mem_req [NREQ-1:0]   req_pkt = '0;
  logic [NREQ-1:0]       req_gnt;
  logic                  mem_req_valid;
  t_mem_req              mem_req_pkt;
  logic                  mem_req_ready = 1'b0;
  logic                  mem_rsp_valid = 1'b0;
  logic                  drain_req = 1'b0;
  logic                  drain_done;
  logic [CW-1:0]         credits;
  logic [NREQ-1:0][31:0] perf_gnt_cnt;
  logic [31:0]           perf_stall_cnt;

  mem_req_sched #(.NREQ(NREQ), .NCRED(NCRED)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_pkt        (req_pkt),
    .req_gnt        (req_gnt),
    .mem_req_valid  (mem_req_valid),
    .mem_req_pkt    (mem_req_pkt),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .credits        (credits),
    .perf_gnt_cnt   (perf_gnt_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Model: mode 0=running, 1=draining, 2=drained.
  int          m_mode;
  int          m_cred;
  int          m_ptr;
  bit          m_oval;
  t_mem_req    m_opkt;
  int unsigned m_gcnt [NREQ];
  int unsigned m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cred = NCRED;
    m_ptr  = 0;
    m_oval = 1'b0;
    m_opkt = '0;
    m_stall = 0;
    for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
  endtask

  // Winner index or -1: only while running, with a free credit and a free
  // (or emptying) output slot; first asserted requester from the pointer.
  function automatic int model_pick(input logic [NREQ-1:0] v, input bit rdy);
    if (m_mode != 0 || m_cred == 0 || (m_oval && !rdy)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(mem_req_valid), 64'(m_oval));
    check({tag, ".pkt"}, 64'(mem_req_pkt), 64'(m_opkt));
    check({tag, ".credits"}, 64'(credits), 64'(m_cred));
    check({tag, ".drain_done"}, 64'(drain_done), 64'(m_mode == 2));
`ifdef MEM_REQ_SCHED_PERF_EN
    for (int i = 0; i < NREQ; i++)
      check({tag, ".perf_gnt"}, 64'(perf_gnt_cnt[i]), 64'(m_gcnt[i]));
    check({tag, ".perf_stall"}, 64'(perf_stall_cnt), 64'(m_stall));
`else
    check({tag, ".perf_gnt"}, 64'(perf_gnt_cnt), 64'd0);
    check({tag, ".perf_stall"}, 64'(perf_stall_cnt), 64'd0);
`endif
  endtask

  // One clock of traffic; entered and left at posedge+1.
  task automatic cycle(input logic [NREQ-1:0] v, input bit rdy, input bit rsp, input bit drn);
    logic [NREQ-1:0] exp_gnt;
    int g;
    bit rsp_eff;
    bit nv;
    int nc;
    rsp_eff = rsp && (m_cred < NCRED);
    req_valid     = v;
    mem_req_ready = rdy;
    mem_rsp_valid = rsp_eff;
    drain_req     = drn;
    for (int i = 0; i < NREQ; i++) begin
      req_pkt[i].addr = $urandom;
      req_pkt[i].id   = 4'($urandom);
      req_pkt[i].we   = 1'($urandom);
    end
    #2;
    g = model_pick(v, rdy);
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check("req_gnt", 64'(req_gnt), 64'(exp_gnt));
    @(posedge clk);
    #1;
    if ((|v) && m_cred == 0) m_stall++;
    if (g >= 0) begin
      m_gcnt[g]++;
      m_opkt = req_pkt[g];
      m_ptr  = (g + 1) % NREQ;
    end
    nv = (g >= 0) || (m_oval && !rdy);
    nc = m_cred - ((g >= 0) ? 1 : 0) + (rsp_eff ? 1 : 0);
    case (m_mode)
      0: if (drn) m_mode = 1;
      1: if (!drn) m_mode = 0;
         else if (nc == NCRED && !nv) m_mode = 2;
      default: if (!drn) m_mode = 0;
    endcase
    m_oval = nv;
    m_cred = nc;
    cyc++;
    $display("cyc %0d v=%b rdy=%b rsp=%b drn=%b gnt=%b exp_gnt=%b valid=%b cred=%0d done=%b",
             cyc, v, rdy, rsp_eff, drn, req_gnt, exp_gnt, mem_req_valid, credits, drain_done);
    check_outputs("cyc");
  endtask

  // Async reset, checked before any clock edge; optional response pulse
  // while held in reset must be ignored.
  task automatic apply_reset(input bit rsp_in_reset);
    reset = 1'b0;
    req_valid = '0;
    mem_req_ready = 1'b0;
    drain_req = 1'b0;
    mem_rsp_valid = rsp_in_reset;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    check("reset.rsp_ignored", 64'(credits), 64'(NCRED));
    reset = 1'b1;
    $display("reset applied at %0t", $time);
  endtask

  initial begin
    bit drn;
    #2;
    apply_reset(1'b0);

    // Both requesting, memory ready, responses streaming: grants alternate.
    for (int n = 0; n < 8; n++) cycle(2'b11, 1'b1, 1'b1, 1'b0);

    // Credit exhaustion without responses, then one response frees a slot.
    apply_reset(1'b0);
    for (int n = 0; n < 6; n++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
    check("exhaust.credits", 64'(credits), 64'd0);
    cycle(2'b11, 1'b1, 1'b1, 1'b0);
    check("exhaust.one_back", 64'(credits), 64'd1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    check("exhaust.fifth", 64'(credits), 64'd0);

    // Back-pressure for three cycles, then release with back-to-back grant.
    apply_reset(1'b0);
    cycle(2'b01, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) cycle(2'b11, 1'b0, 1'b0, 1'b0);
    check("bp.credits", 64'(credits), 64'(NCRED - 1));
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    check("bp.after", 64'(credits), 64'(NCRED - 2));

    // Grant and response in the same cycle at two credits.
    apply_reset(1'b0);
    cycle(2'b01, 1'b1, 1'b0, 1'b0);
    cycle(2'b10, 1'b1, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 1'b1, 1'b0);
    check("same_cycle.credits", 64'(credits), 64'd2);

    // Drain with three outstanding.
    apply_reset(1'b0);
    for (int n = 0; n < 3; n++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 1'b1, 1'b1);
    cycle(2'b11, 1'b1, 1'b1, 1'b1);
    check("drain.not_yet", 64'(drain_done), 64'd0);
    cycle(2'b11, 1'b1, 1'b1, 1'b1);
    check("drain.done", 64'(drain_done), 64'd1);
    cycle(2'b11, 1'b1, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    check("drain.resumed", 64'(credits), 64'(NCRED - 1));

    // Reset in the middle of a stalled handshake with one credit left.
    apply_reset(1'b0);
    for (int n = 0; n < 3; n++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("midrst.pre_cred", 64'(credits), 64'd1);
    apply_reset(1'b1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0);
    check("midrst.first_gnt_to_0", 64'(mem_req_pkt), 64'(req_pkt[0]));

    // Random traffic against the model.
    apply_reset(1'b0);
    drn = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) drn = ~drn;
      cycle(NREQ'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), drn);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
